// File: rtl/load_store_unit_if.sv
// CPU-side request/response channel of the load/store unit.
// The unit sits on the slave modport. The CPU or bench sits on the master modport.
interface load_store_unit_if;
   logic        reqValid;
   logic        reqReady;
   logic        reqWrite;
   logic [1:0]  reqSize;
   logic        reqSigned;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;
   logic        respValid;
   logic        respReady;
   logic [31:0] respRdata;
   logic        respErr;

   modport master (
      output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWdata, respReady,
      input  reqReady, respValid, respRdata, respErr
   );

   modport slave (
      input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWdata, respReady,
      output reqReady, respValid, respRdata, respErr
   );
endinterface

// File: rtl/load_store_unit.sv
// Turns CPU byte/half/word loads and stores into word accesses. Sub-word stores use read-modify-write.
// Latency: error 1, word store 2, load 1+RL, sub-word store 2+RL; one request in flight; RESP holds until respReady.
module load_store_unit #(
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   load_store_unit_if.slave        cpu,
   output logic [31:0]             memAddress,
   output logic [31:0]             memDataIn,
   output logic                    memWEn,
   output logic                    memRst,
   input  logic [31:0]             memDataOut
);

   typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

   localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

   state_t      state, state_nxt;
   logic [31:0] addr_q;
   logic [31:0] word_q;
   logic [31:0] rdata_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic        err_q;
   logic [1:0]  cnt;

   logic        req_err;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_val;
   logic [31:0] merge_val;

   always_comb begin
      req_err = (cpu.reqSize == 2'b11)
             || (cpu.reqSize == 2'b01 && cpu.reqAddr[0])
             || (cpu.reqSize == 2'b10 && cpu.reqAddr[1:0] != 2'b00);
   end

   // Lane extraction and merge both work on the word currently on memDataOut.
   always_comb begin
      byte_v    = memDataOut[{addr_q[1:0], 3'b000} +: 8];
      half_v    = memDataOut[{addr_q[1], 4'b0000} +: 16];
      load_val  = memDataOut;
      merge_val = memDataOut;
      case (size_q)
         2'b00: begin
            load_val = signed_q ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
            merge_val[{addr_q[1:0], 3'b000} +: 8] = word_q[7:0];
         end
         2'b01: begin
            load_val = signed_q ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
            merge_val[{addr_q[1], 4'b0000} +: 16] = word_q[15:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cpu.reqValid) begin
               if (req_err)                     state_nxt = RESP;
               else if (!cpu.reqWrite)          state_nxt = RD;
               else if (cpu.reqSize == 2'b10)   state_nxt = WR;
               else                             state_nxt = RMW_RD;
            end
         end
         RD:     if (cnt == 2'd0) state_nxt = RESP;
         RMW_RD: if (cnt == 2'd0) state_nxt = WR;
         WR:     state_nxt = RESP;
         RESP:   if (cpu.respReady) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         addr_q   <= '0;
         word_q   <= '0;
         rdata_q  <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
         cnt      <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (cpu.reqValid) begin
                  addr_q   <= cpu.reqAddr;
                  word_q   <= cpu.reqWdata;
                  size_q   <= cpu.reqSize;
                  signed_q <= cpu.reqSigned;
                  err_q    <= req_err;
                  rdata_q  <= '0;
                  cnt      <= CNT_INIT;
               end
            end
            RD: begin
               if (cnt == 2'd0) rdata_q <= load_val;
               else             cnt     <= cnt - 2'd1;
            end
            RMW_RD: begin
               if (cnt == 2'd0) word_q <= merge_val;
               else             cnt    <= cnt - 2'd1;
            end
            RESP: begin
               if (cpu.respReady) begin
                  rdata_q <= '0;
                  err_q   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign cpu.reqReady  = (state == IDLE);
   assign cpu.respValid = (state == RESP);
   assign cpu.respRdata = rdata_q;
   assign cpu.respErr   = err_q;

   assign memAddress = (state == IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
   assign memDataIn  = (state == WR) ? word_q : 32'h0;
   assign memWEn     = (state == WR);
   assign memRst     = ~rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: the stimulus process pushes expected responses/writes, and the negedge monitor pops and compares them.
module tb_load_store_unit;
   localparam int RL = 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      int          stall;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] memAddress, memDataIn, memDataOut;
   logic        memWEn, memRst;

   load_store_unit_if bus ();

   load_store_unit #(.READ_LATENCY(RL)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu        (bus),
      .memAddress (memAddress),
      .memDataIn  (memDataIn),
      .memWEn     (memWEn),
      .memRst     (memRst),
      .memDataOut (memDataOut)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];
   assign memDataOut = mem[memAddress[7:2]];

   always @(posedge clk) begin
      if (cyc == 0) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      end else if (memWEn) begin
         mem[memAddress[7:2]] <= memDataIn;
      end
   end

   exp_t exp_q [$];
   wr_t  wr_q  [$];
   int   checks = 0;
   int   errors = 0;
   int   timeouts = 0;
   bit   chk_reset = 1'b0;
   bit   chk_end = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor/scoreboard: all comparisons happen here
   bit          in_resp = 1'b0;
   int          stall_left = 0;
   logic [31:0] cap_rdata;
   logic        cap_err;
   always @(negedge clk) begin
      if (chk_reset) begin
         chk("rst_reqReady", 32'(bus.reqReady), 32'd1);
         chk("rst_respValid", 32'(bus.respValid), 32'd0);
         chk("rst_respRdata", bus.respRdata, 32'd0);
         chk("rst_respErr", 32'(bus.respErr), 32'd0);
         chk("rst_memAddress", memAddress, 32'd0);
         chk("rst_memDataIn", memDataIn, 32'd0);
         chk("rst_memWEn", 32'(memWEn), 32'd0);
         chk("rst_memRst", 32'(memRst), 32'd1);
         chk("rst_mem_word_kept", mem[20], ref_mem[20]);
      end
      if (chk_end) begin
         int bad;
         bad = 0;
         for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
         chk("end_mem_words_differing", 32'(bad), 32'd0);
         chk("end_resp_queue_left", 32'(exp_q.size()), 32'd0);
         chk("end_write_queue_left", 32'(wr_q.size()), 32'd0);
         chk("end_timeouts", 32'(timeouts), 32'd0);
         chk("end_memRst", 32'(memRst), 32'd0);
      end
      if (!rst) begin
         in_resp = 1'b0;
         stall_left = 0;
         bus.respReady = 1'b0;
      end else begin
         if (memWEn) begin
            if (wr_q.size() == 0) begin
               chk("unexpected_memWEn", 32'd1, 32'd0);
            end else begin
               wr_t w;
               w = wr_q.pop_front();
               chk("wr_addr", memAddress, w.addr);
               chk("wr_data", memDataIn, w.data);
               chk("wr_cycle", 32'(cyc), 32'(w.cyc));
            end
         end
         if (bus.respValid) begin
            if (!in_resp) begin
               in_resp = 1'b1;
               cap_rdata = bus.respRdata;
               cap_err = bus.respErr;
               if (exp_q.size() == 0) begin
                  chk("unexpected_resp", 32'd1, 32'd0);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("resp_rdata", bus.respRdata, e.rdata);
                  chk("resp_err", 32'(bus.respErr), 32'(e.err));
                  chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                  stall_left = e.stall;
               end
            end else begin
               chk("held_rdata", bus.respRdata, cap_rdata);
               chk("held_err", 32'(bus.respErr), 32'(cap_err));
            end
            chk("reqReady_during_resp", 32'(bus.reqReady), 32'd0);
            if (stall_left > 0) begin
               bus.respReady = 1'b0;
               stall_left--;
            end else begin
               bus.respReady = ($urandom_range(0, 3) != 0);
            end
            if (bus.respReady) in_resp = 1'b0;
         end else begin
            bus.respReady = 1'($urandom_range(0, 1));
         end
      end
   end

   // Reference model: plain masks/shifts on a word array; pushes expectations at accept time.
   task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit push, input int stall);
      exp_t        e;
      wr_t         x;
      int          acc, waited, sh;
      logic [31:0] word, mask, lane;
      bit          err;
      err  = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
      mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      sh   = (sz == 2'd1) ? int'(a & 2) * 8 : int'(a & 3) * 8;
      @(negedge clk);
      bus.reqValid  = 1'b1;
      bus.reqWrite  = w;
      bus.reqSize   = sz;
      bus.reqSigned = sg;
      bus.reqAddr   = a;
      bus.reqWdata  = wd;
      waited = 0;
      while (!bus.reqReady && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 500) timeouts++;
      acc  = cyc + 1;
      word = ref_mem[a[7:2]];
      e.stall = stall;
      e.rdata = 32'h0;
      e.err   = err;
      if (err) begin
         e.cyc = acc;
      end else if (!w) begin
         lane = (word >> sh) & mask;
         if (sg && sz != 2'd2 && (lane & ((mask >> 1) + 1)) != 0) lane = lane | ~mask;
         e.rdata = lane;
         e.cyc = acc + RL;
      end else begin
         x.addr = a & 32'hFFFF_FFFC;
         x.data = (word & ~(mask << sh)) | ((wd & mask) << sh);
         x.cyc  = (sz == 2'd2) ? acc : acc + RL;
         e.cyc  = (sz == 2'd2) ? acc + 1 : acc + 1 + RL;
         if (push) begin
            wr_q.push_back(x);
            ref_mem[a[7:2]] = x.data;
         end
      end
      if (push) exp_q.push_back(e);
      @(posedge clk);
      #1 bus.reqValid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) timeouts++;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
      bus.reqValid = 1'b0;
      bus.reqWrite = 1'b0;
      bus.reqSize = 2'b00;
      bus.reqSigned = 1'b0;
      bus.reqAddr = 32'h0;
      bus.reqWdata = 32'h0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_reset = 1'b1;
      @(negedge clk);
      #1 chk_reset = 1'b0;
      rst = 1'b1;

      // Word store then load back
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 0);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 0);
      // Byte/half extraction with extension
      issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, 1'b1, 0);
      issue(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 1'b1, 0);
      issue(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 1'b1, 0);
      issue(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 1'b1, 0);
      issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b1, 0);
      // Sub-word read-modify-write
      issue(1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344, 1'b1, 0);
      issue(1'b1, 2'd0, 1'b0, 32'h31, 32'h555555AA, 1'b1, 0);
      issue(1'b1, 2'd1, 1'b0, 32'h32, 32'h1234BEEF, 1'b1, 0);
      issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1, 0);
      // Errors: misaligned word, misaligned half, illegal size
      issue(1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 1'b1, 0);
      issue(1'b1, 2'd1, 1'b0, 32'h43, 32'hFFFF, 1'b1, 0);
      issue(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 1'b1, 0);
      // Backpressure: response held 5 cycles while the next request waits
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 5);
      issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 0);
      drain();

      // Reset during the read phase of a byte store aborts it
      issue(1'b1, 2'd2, 1'b0, 32'h50, 32'hCAFEF00D, 1'b1, 0);
      drain();
      issue(1'b1, 2'd0, 1'b0, 32'h51, 32'h77, 1'b0, 0);
      rst = 1'b0;
      @(posedge clk);
      #1 chk_reset = 1'b1;
      @(negedge clk);
      #1 chk_reset = 1'b0;
      rst = 1'b1;
      issue(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 1'b1, 0);

      for (int n = 0; n < 300; n++) begin
         logic [1:0] sz;
         sz = 2'($urandom_range(0, 15) == 0 ? 3 : $urandom_range(0, 2));
         issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 255)), $urandom, 1'b1,
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
      end
      drain();

      @(posedge clk);
      #1 chk_end = 1'b1;
      @(negedge clk);
      #1 chk_end = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits directly upstream of the integrated memory/peripheral block and feeds it. Converts CPU load/store requests (valid/ready, byte/half/word, signed/unsigned) into word-wide accesses on the memory's virtual-address port. Sub-word stores are done as read-modify-write. Load data is aligned and sign/zero-extended before it is returned on a registered valid/ready response channel.

## Interface
- READ_LATENCY, 1: cycles from address presented to memDataOut valid (legal 1..3).
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- reqValid  in  1  request present
- reqReady  out  1  unit can accept request (high only in IDLE)
- reqWrite  in  1  1 = store, 0 = load
- reqSize  in  2  00 byte, 01 half, 10 word, 11 illegal
- reqSigned  in  1  loads: 1 = sign-extend, 0 = zero-extend; ignored for stores
- reqAddr  in  32  byte address
- reqWdata  in  32  store data, right-justified
- respValid  out  1  response available
- respReady  in  1  CPU accepts response
- respRdata  out  32  extended load data; 0 for stores and errors
- respErr  out  1  misaligned or illegal size; no memory access made
- memAddress  out  32  to memory addressVirt, always {addr[31:2],2'b00}
- memDataIn  out  32  to memory dataInVirt
- memWEn  out  1  to memory wEnVirt, one-cycle pulse
- memRst  out  1  to memory rstVirt, equals ~rst (combinational)
- memDataOut  in  32  from memory dataOutVirt

## Operation
- Little-endian: byte lane n = addr[1:0] occupies bits [8n+7:8n]; halfword lane uses addr[1].
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0. Misaligned or size 11 → RESP with respErr=1, memWEn never asserted.
- States:
  - IDLE: reqReady=1. On reqValid, latch the request.
    - error → RESP
    - load → RD
    - word store → WR
    - byte/half store → RMW_RD
  - RD: drive memAddress for READ_LATENCY cycles (down-counter). In the last cycle, sample memDataOut, extract the lane, extend it, and register it into respRdata → RESP.
  - RMW_RD: same as RD, but the sampled word is merged with the lane of reqWdata (other bytes preserved) → WR.
  - WR: memDataIn = full word or merged word, memWEn=1 for exactly this cycle → RESP.
  - RESP: respValid=1; respRdata and respErr held stable until respReady → IDLE.
- memAddress is held at the latched address in every non-IDLE state and at 0 in IDLE. memDataIn is 0 except in WR.
- reqValid while not in IDLE is ignored (reqReady=0). Requests are never dropped once accepted.

## Timing
- Reset (rst low at a clock edge) gives, from the next cycle:
  - state IDLE, counter 0
  - reqReady=1, respValid=0, respRdata=0, respErr=0
  - memAddress=0, memDataIn=0, memWEn=0
- Reset mid-operation aborts the operation. A write still in WR at that edge completes only that cycle's pulse; no response is produced.
- memRst follows rst with zero delay, so memory resets in the same cycles.
- Request accepted at edge T. Minimum latency to respValid high:
  - load: T+1+READ_LATENCY
  - word store: T+2
  - sub-word store: T+2+READ_LATENCY
  - error: T+1
- Back-to-back: respReady high in the first RESP cycle gives IDLE the next cycle. Throughput is one request per (latency+1) cycles.
- respValid=1 with respReady=0 holds indefinitely; outputs must not change while held.
- With READ_LATENCY=1, the RMW write-back pulse occurs exactly 2 cycles after the accept edge. No other memWEn pulses occur.

## Test plan
- Word store/load: store 0xDEADBEEF @0x10, then load word @0x10 → memWEn one pulse, memDataIn=0xDEADBEEF; load respRdata=0xDEADBEEF, respErr=0, respValid at accept+2 (READ_LATENCY=1).
- Byte loads: word 0x80FF7F01 @0x20. Signed byte @0x23 → 0xFFFFFF80. Unsigned @0x23 → 0x00000080. Signed byte @0x20 → 0x00000001. Signed half @0x22 → 0xFFFF80FF.
- Sub-word store RMW: word 0x11223344 @0x30. Store byte 0xAA @0x31 → write-back 0x1122AA44. Then half 0xBEEF @0x32 → 0xBEEFAA44. Exactly one memWEn per store.
- Errors: word @0x41, half @0x43, size 11 @0x40 → respErr=1, respRdata=0, memWEn never high, respValid at accept+1.
- Backpressure: hold respReady=0 for 5 cycles after respValid → reqReady=0 and respRdata stable throughout. New reqValid is not accepted until after the handshake.
- Reset: pull rst low during RMW_RD of a byte store → all outputs at reset values next cycle, memory word unchanged, memRst high during reset. A load after release is correct.
